// File: rtl/data_sniffer_pkg.sv
// Shared constants, detector state encoding and byte classification
// for the phone-number sniffer.
package data_sniffer_pkg;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;
    localparam logic [7:0] SPACE = 8'h20;

    localparam int DIGITS_DEF = 9;
    localparam int GROUP_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEP     = 2'd2,
        SKIP    = 2'd3
    } det_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ZERO) && (b <= NINE);
    endfunction

endpackage

// File: rtl/data_sniffer_ser.sv
// One-entry pending register feeding a serializer that emits the stored
// digits followed by a space terminator, one byte per cycle.
module data_sniffer_ser
    import data_sniffer_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  confirm,
    input  logic [DIGITS*4-1:0]   digits,
    output logic [7:0]            data_out,
    output logic                  write
);

    localparam int BW = DIGITS * 4;
    localparam int IW = $clog2(DIGITS + 1);

    logic [BW-1:0] pend;
    logic [BW-1:0] shreg;
    logic          pend_full;
    logic          busy;
    logic [IW-1:0] idx;
    logic          load;

    assign load = !busy && pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            pend_full <= 1'b0;
            shreg     <= '0;
            busy      <= 1'b0;
            idx       <= '0;
            data_out  <= 8'h00;
            write     <= 1'b0;
        end else begin
            // A confirm on the same edge as a load refills the slot the load just drained.
            if (confirm) begin
                pend      <= digits;
                pend_full <= 1'b1;
            end else if (load) begin
                pend_full <= 1'b0;
            end

            if (busy) begin
                write <= 1'b1;
                if (idx == IW'(DIGITS)) begin
                    data_out <= SPACE;
                    busy     <= 1'b0;
                end else begin
                    data_out <= ZERO | {4'h0, shreg[BW-1 -: 4]};
                    shreg    <= shreg << 4;
                    idx      <= idx + IW'(1);
                end
            end else if (load) begin
                write    <= 1'b1;
                data_out <= ZERO | {4'h0, pend[BW-1 -: 4]};
                shreg    <= pend << 4;
                idx      <= IW'(1);
                busy     <= 1'b1;
            end else begin
                write <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_sniffer.sv
// Streaming detector for digit runs of DIGITS length, optionally split into
// GROUP-sized blocks by single spaces; confirmed numbers go to the serializer.
module data_sniffer
    import data_sniffer_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int GROUP  = GROUP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       write
);

    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);

    det_state_t    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [BW-1:0] digits, digits_nxt;
    logic          confirm;
    logic          in_digit;
    logic          in_space;
    logic          on_group;

    assign in_digit = is_digit(data_in);
    assign in_space = (data_in == SPACE);
    assign on_group = ((int'(count) % GROUP) == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            digits <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            digits <= digits_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        digits_nxt = digits;
        confirm    = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (in_digit) begin
                        digits_nxt = {digits[BW-5:0], data_in[3:0]};
                        count_nxt  = CW'(1);
                        state_nxt  = COLLECT;
                    end
                end
                COLLECT: begin
                    // A full count takes priority, so a trailing space is a terminator.
                    if (count == CW'(DIGITS)) begin
                        if (in_digit) begin
                            state_nxt = SKIP;
                        end else begin
                            confirm   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (in_digit) begin
                        digits_nxt = {digits[BW-5:0], data_in[3:0]};
                        count_nxt  = count + CW'(1);
                    end else if (in_space && on_group) begin
                        state_nxt = SEP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                SEP: begin
                    if (in_digit) begin
                        digits_nxt = {digits[BW-5:0], data_in[3:0]};
                        count_nxt  = count + CW'(1);
                        state_nxt  = COLLECT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                SKIP: begin
                    if (!in_digit) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    data_sniffer_ser #(
        .DIGITS (DIGITS)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .confirm  (confirm),
        .digits   (digits),
        .data_out (data_out),
        .write    (write)
    );

endmodule

// File: tb/tb_data_sniffer.sv
// Directed bench for data_sniffer: byte streams in, captured records compared
// against hand-written expected strings and timing.
module tb_data_sniffer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       write;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] cap[$];
    int         capt[$];

    data_sniffer dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out),
        .write    (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (write === 1'b1) begin
            cap.push_back(data_out);
            capt.push_back(cyc);
        end
    end

    function automatic string cap_str();
        string s = "";
        foreach (cap[i]) s = {s, $sformatf("%c", cap[i])};
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        enable  = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable  = 1'b0;
            data_in = 8'h2E;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        enable  = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cap.delete();
        capt.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        enable  = 1'b1;
        data_in = 8'h31;
        repeat (2) @(negedge clk);
        checks++;
        if (write !== 1'b0) begin
            failures++;
            $display("FAIL reset_write got=%b exp=0", write);
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data_out got=%h exp=00", data_out);
        end
        rst = 1'b0;
        idle(3);
        checks++;
        if (cap.size() != 0) begin
            failures++;
            $display("FAIL reset_no_output got=%0d bytes exp=0", cap.size());
        end
    endtask

    task automatic test_basic();
        string s = "a729 992 561ff729892561gsdf";
        int    t_term = 0;
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (i == 12) t_term = cyc;
        end
        idle(25);
        checks++;
        if (cap.size() != 20) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=20", cap.size());
        end
        checks++;
        if (cap_str() != "729992561 729892561 ") begin
            failures++;
            $display("FAIL basic_data got=\"%s\" exp=\"729992561 729892561 \"", cap_str());
        end
        checks++;
        if (capt.size() == 0 || capt[0] != t_term + 2) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=%0d", (capt.size() == 0) ? -1 : capt[0], t_term + 2);
        end
    endtask

    task automatic test_long();
        do_reset();
        send_str("1234567890x");
        idle(15);
        checks++;
        if (cap.size() != 0) begin
            failures++;
            $display("FAIL long_run got=\"%s\" exp=\"\"", cap_str());
        end
        do_reset();
        send_str("x123456789x");
        idle(15);
        checks++;
        if (cap_str() != "123456789 ") begin
            failures++;
            $display("FAIL exact_nine got=\"%s\" exp=\"123456789 \"", cap_str());
        end
    endtask

    task automatic test_group_err();
        do_reset();
        send_str("12 3456789x");
        idle(15);
        checks++;
        if (cap.size() != 0) begin
            failures++;
            $display("FAIL off_group_space got=\"%s\" exp=\"\"", cap_str());
        end
        do_reset();
        send_str("123  456 789x");
        idle(15);
        checks++;
        if (cap.size() != 0) begin
            failures++;
            $display("FAIL double_space got=\"%s\" exp=\"\"", cap_str());
        end
    endtask

    task automatic test_rearm();
        do_reset();
        send_str("1 234 567 890#");
        idle(15);
        checks++;
        if (cap_str() != "234567890 ") begin
            failures++;
            $display("FAIL rearm got=\"%s\" exp=\"234567890 \"", cap_str());
        end
    endtask

    task automatic test_unterminated();
        do_reset();
        send_str("x123456789");
        idle(20);
        checks++;
        if (cap.size() != 0) begin
            failures++;
            $display("FAIL unterminated got=\"%s\" exp=\"\"", cap_str());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_str("111222333 444555666 ");
        idle(30);
        checks++;
        if (cap_str() != "111222333 444555666 ") begin
            failures++;
            $display("FAIL b2b_data got=\"%s\" exp=\"111222333 444555666 \"", cap_str());
        end
        checks++;
        if (cap.size() != 20 || capt[19] - capt[0] != 19) begin
            failures++;
            $display("FAIL b2b_contiguous got=%0d bytes span=%0d exp=20 bytes span=19",
                     cap.size(), (cap.size() >= 2) ? capt[capt.size()-1] - capt[0] : -1);
        end
    endtask

    task automatic test_enable();
        do_reset();
        send_str("x12345");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            enable  = 1'b0;
            data_in = (i % 2 == 0) ? 8'h39 : 8'h7A;
        end
        send_str("6789x");
        idle(15);
        checks++;
        if (cap_str() != "123456789 ") begin
            failures++;
            $display("FAIL enable_freeze got=\"%s\" exp=\"123456789 \"", cap_str());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        send_str("111222333 444555666 ");
        idle(3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (write !== 1'b0) begin
            failures++;
            $display("FAIL midrst_write got=%b exp=0", write);
        end
        n = cap.size();
        checks++;
        if (n == 0 || n >= 20) begin
            failures++;
            $display("FAIL midrst_partial got=%0d bytes exp=1..19", n);
        end
        rst = 1'b0;
        idle(30);
        checks++;
        if (cap.size() != n) begin
            failures++;
            $display("FAIL midrst_silent got=%0d bytes exp=%0d", cap.size(), n);
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_basic();
        test_long();
        test_group_err();
        test_rearm();
        test_unterminated();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_sniffer.md
Name: data_sniffer

Overview:
- Streaming ASCII filter: accepts one byte per clock and detects 9-digit phone numbers embedded in arbitrary text.
- Accepted formats: "DDDDDDDDD", or digit groups of 3 separated by single spaces ("DDD DDD DDD").
- Each detected number is re-emitted in normalised form (9 digits, no spaces) followed by one space byte (8'h20) as a record terminator, one byte per cycle with a write strobe.
- Sits between a byte source (UART RX or similar) and a byte sink/logger.

Parameters:
- DIGITS, 9, number of digits in a valid number.
- GROUP, 3, group length at whose boundaries a single space separator is permitted; DIGITS must be a multiple of GROUP.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  data_in is sampled only on edges where enable=1.
- data_in  in  8  ASCII input byte.
- data_out  out  8  emitted ASCII byte; valid when write=1.
- write  out  1  one-cycle strobe per emitted byte.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: data_out=8'h00, write=0, detector in IDLE, digit count 0, serializer idle, pending slot empty.
- Digit = 8'h30..8'h39. Space = 8'h20. Every other byte is "other".
- Detector states, advanced only on enabled edges; enable=0 freezes the detector.
- IDLE (previous byte non-digit): digit -> store as digit 1, go to COLLECT; otherwise stay in IDLE.
- COLLECT, count<DIGITS: digit -> store, count++.
  - Space with count a multiple of GROUP (3 or 6) -> go to SEP.
  - Any other space or "other" byte -> discard candidate, go to IDLE.
- SEP: digit -> store, count++, go to COLLECT. Any non-digit (including a second space) -> discard, go to IDLE.
- COLLECT, count==DIGITS: non-digit (terminator) -> CONFIRM number, go to IDLE. Digit -> run too long, go to SKIP.
- SKIP: stay while input is a digit; first non-digit -> IDLE.
- Consequences:
  - A digit immediately following a digit never starts a candidate.
  - The aborting non-digit byte re-arms IDLE, so "1 234 567 890" yields 234567890.
  - The terminator may be any non-digit and also serves as the leading boundary of the next number.
  - An unterminated trailing number is never emitted.
- CONFIRM copies the 9 digits into a one-entry pending register.
- Serializer:
  - When idle and pending is full, it loads pending and clears it.
  - It then outputs the 9 digits, then 8'h20, on 10 consecutive cycles with write=1.
  - Latency: the first digit appears on the edge after the confirming edge (write=1 for cycles T+1..T+10).
- If a CONFIRM occurs while the serializer is busy, the number waits in pending and emission follows back-to-back. Confirms are ≥10 cycles apart, so one pending slot never overflows.
- Serializer runs regardless of enable.
- write=0 when not emitting; data_out holds the last emitted byte.
- rst mid-operation aborts the candidate, pending entry and in-progress emission immediately.

Decomposition:
- Package data_sniffer_pkg: ASCII constants (ZERO, NINE, SPACE), DIGITS/GROUP defaults, detector state enum (IDLE, COLLECT, SEP, SKIP), is_digit function.
- One sub-module, data_sniffer_ser: pending register plus 10-byte serializer producing data_out/write.
- Detector FSM lives in the top level.

Test Plan:
- Stream "a729 992 561ff729892561gsdf" with enable=1 after reset -> exactly "729992561 " then "729892561 " emitted (20 write pulses). The first digit appears one cycle after 'f' is sampled.
- Stream "1234567890x" -> no output (10-digit run hits SKIP). Stream "x123456789x" -> "123456789 ".
- Stream "12 3456789x" and "123  456 789x" -> no output (space off a group boundary; double space).
- Stream "1 234 567 890#" -> "234567890 ".
- Stream "111222333 444555666 " with no gap -> two records back-to-back, 20 consecutive write cycles. Pending slot is used; no byte lost.
- Toggle enable=0 for 5 cycles mid-number, holding junk on data_in -> junk ignored, number still detected. Assert rst during emission -> write=0 on the next cycle, nothing further emitted.
